branch_predictor: RTL

- Fetch-side direction/target predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
- Sits directly upstream of the execute-stage branch resolution unit.
- Supplies each fetch PC's predicted direction and target, which travel down the pipe as predict_to_branch / pc_predict.
- Is trained by that unit's resolved outcome (fact_pc, fact_taken, fact_tpc, dir/addr fail flags).
- Also keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry, one-cycle registered lookup, trained by execute-stage resolution.
module branch_predictor #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 20
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_valid,
    output logic [31:0] pred_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_tpc,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_fact_pc,
    input  logic        ex_fact_taken,
    input  logic [31:0] ex_fact_tpc,
    input  logic        ex_dir_fail,
    input  logic        ex_addr_fail,
    output logic [31:0] stat_br_cnt,
    output logic [31:0] stat_misp_cnt
);

    localparam int          ENTRIES   = 1 << INDEX_W;
    localparam int          TAG_LO    = INDEX_W + 2;
    localparam int          TAG_HI    = INDEX_W + TAG_W + 1;
    localparam logic [1:0]  CTR_INIT  = 2'b01;
    localparam logic [1:0]  CTR_ALLOC = 2'b10;

    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    // Stage p0: lookup against the table contents before this edge's update (read-first)
    logic [INDEX_W-1:0] lk_idx_p0;
    logic [TAG_W-1:0]   lk_tag_p0;
    logic               lk_hit_p0;
    logic               lk_taken_p0;
    logic [31:0]        lk_tpc_p0;

    always_comb begin
        lk_idx_p0   = if_pc[TAG_LO-1:2];
        lk_tag_p0   = if_pc[TAG_HI:TAG_LO];
        lk_hit_p0   = valid_q[lk_idx_p0] && (tag_q[lk_idx_p0] == lk_tag_p0);
        lk_taken_p0 = lk_hit_p0 && ctr_q[lk_idx_p0][1];
        lk_tpc_p0   = lk_taken_p0 ? tgt_q[lk_idx_p0] : if_pc + 32'd4;
    end

    logic [INDEX_W-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_en;
    logic               up_hit;
    logic               up_alloc;
    logic               up_misp;

    always_comb begin
        up_idx   = ex_fact_pc[TAG_LO-1:2];
        up_tag   = ex_fact_pc[TAG_HI:TAG_LO];
        up_en    = ex_valid && ex_is_branch;
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_alloc = up_en && !up_hit && ex_fact_taken;
        up_misp  = up_en && (ex_dir_fail || ex_addr_fail);
    end

    // PC bits outside index/tag (byte offset and upper bits) do not take part in the lookup
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1],
                              ex_fact_pc[1:0], ex_fact_pc[31:TAG_HI+1]};

    // Stage p1: registered prediction outputs
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pred_valid <= 1'b0;
            pred_pc    <= '0;
            pred_hit   <= 1'b0;
            pred_taken <= 1'b0;
            pred_tpc   <= '0;
        end else begin
            pred_valid <= if_valid;
            if (if_valid) begin
                pred_pc    <= if_pc;
                pred_hit   <= lk_hit_p0;
                pred_taken <= lk_taken_p0;
                pred_tpc   <= lk_tpc_p0;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (up_en) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ex_fact_taken ? ctr_sat_inc(ctr_q[up_idx])
                                               : ctr_sat_dec(ctr_q[up_idx]);
            end else if (ex_fact_taken) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= CTR_ALLOC;
            end
        end
    end

    // Tag/target storage carries no reset; stale contents are masked by valid_q
    always_ff @(posedge clk) begin
        if (up_en && ex_fact_taken) begin
            tgt_q[up_idx] <= ex_fact_tpc;
        end
        if (up_alloc) begin
            tag_q[up_idx] <= up_tag;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_br_cnt   <= '0;
            stat_misp_cnt <= '0;
        end else begin
            if (up_en) begin
                stat_br_cnt <= stat_br_cnt + 32'd1;
            end
            if (up_misp) begin
                stat_misp_cnt <= stat_misp_cnt + 32'd1;
            end
        end
    end

endmodule
